mmio_router: RTL

Parametrised data-side bus router between the core data port, block memory, a secondary memory master, and NUM_CH MMIO peripheral channels.
- Replaces fixed per-peripheral region decode with indexed 256-byte channel windows.
- Each channel uses a req/ack handshake with timeout and core stall (mem_hold).
- The secondary master (e.g. RAS spill engine) gets block memory on cycles the core leaves it idle.

---
 rtl/mmio_router.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mmio_router.sv
// mmio_router: data-side bus router between the core data port, block memory,
// a secondary memory master and NUM_CH MMIO peripheral channels. Each channel owns
// a 256-byte window inside the MMIO page and is driven through a req/ack handshake
// with timeout, stalling the core via mem_hold.
// Optional feature macro: MMIO_ROUTER_STATUS_EN adds a status register at MMIO page
// offset 0x0F0 (timeout count, last timed-out channel, err); writing it clears them.
module mmio_router #(
   parameter int unsigned NUM_CH      = 4,
   parameter logic [19:0] MMIO_BASE   = 20'haaaaa,
   parameter logic [3:0]  CH_BASE_NIB = 4'h4,
   parameter int unsigned TIMEOUT     = 64,
   parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
   input  logic                   clk,
   input  logic                   Rst,
   input  logic                   mem_rea,
   input  logic                   mem_wea,
   input  logic [31:0]            mem_addr,
   input  logic [31:0]            mem_din,
   input  logic [3:0]             mem_en,
   output logic [31:0]            mem_dout,
   output logic                   mem_hold,
   output logic                   blk_en,
   output logic [3:0]             blk_wen,
   output logic [31:0]            blk_addr,
   output logic [31:0]            blk_din,
   input  logic [31:0]            blk_dout,
   input  logic                   sm_rd,
   input  logic                   sm_wr,
   input  logic [31:0]            sm_addr,
   input  logic [31:0]            sm_din,
   output logic [31:0]            sm_dout,
   output logic                   sm_rdy,
   output logic [NUM_CH-1:0]      ch_req,
   output logic                   ch_we,
   output logic [7:0]             ch_addr,
   output logic [31:0]            ch_wdata,
   input  logic [32*NUM_CH-1:0]   ch_rdata,
   input  logic [NUM_CH-1:0]      ch_ack,
   output logic                   err
);

   localparam int unsigned   CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;
   typedef enum logic [1:0] {SelMem, SelCh, SelZero} sel_t;

   state_t            state_q, state_d;
   sel_t              sel_q;
   logic [CW-1:0]     cnt_q;
   logic [31:0]       rdata_q;

   logic              access, is_mmio, is_mem, ch_hit, core_mem;
   logic [3:0]        idx;
   logic [NUM_CH-1:0] idx_onehot;
   logic              ack_hit, expire;
   logic [31:0]       rdata_sel;

`ifdef MMIO_ROUTER_STATUS_EN
   logic              status_hit;
   logic [15:0]       tocount_q;
   logic [3:0]        last_ch_q, idx_q;
   logic [31:0]       status_word;

   assign status_hit  = is_mmio && (mem_addr[11:0] == 12'h0F0);
   assign status_word = {tocount_q, 8'h0, last_ch_q, 3'b0, err};
`endif

   assign access   = mem_rea | mem_wea;
   assign is_mmio  = mem_addr[31:12] == MMIO_BASE;
   assign is_mem   = mem_addr[31:30] == 2'b00;
   assign idx      = mem_addr[11:8] - CH_BASE_NIB;
   assign ch_hit   = is_mmio && (32'(idx) < NUM_CH);
   assign core_mem = access && is_mem;
   assign expire   = cnt_q == CNT_LAST;

   // Channel decode, plus ack/read-data selection keyed off the live one-hot request
   always_comb begin
      idx_onehot = '0;
      rdata_sel  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx_onehot[i] = (idx == 4'(i));
         if (ch_req[i]) rdata_sel = ch_rdata[32*i +: 32];
      end
      ack_hit = |(ch_ack & ch_req);
   end

   // FSM state register
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (access && ch_hit) state_d = StWait;
         StWait:  if (ack_hit || expire) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs: core stall, response mux and block-memory arbitration (core wins)
   always_comb begin
      mem_hold = 1'b0;
      if (!Rst) mem_hold = (state_q == StWait) || (state_q == StIdle && access && ch_hit);

      mem_dout = '0;
      unique case (sel_q)
         SelMem:  mem_dout = blk_dout;
         SelCh:   mem_dout = rdata_q;
         default: mem_dout = '0;
      endcase

      sm_rdy   = !Rst && !core_mem;
      sm_dout  = blk_dout;
      blk_en   = 1'b0;
      blk_wen  = 4'h0;
      blk_addr = '0;
      blk_din  = '0;
      if (core_mem) begin
         blk_en   = 1'b1;
         blk_wen  = mem_wea ? mem_en : 4'h0;
         blk_addr = mem_addr;
         blk_din  = mem_din;
      end else if (sm_rdy && (sm_rd || sm_wr)) begin
         blk_en   = 1'b1;
         blk_wen  = sm_wr ? 4'hF : 4'h0;
         blk_addr = sm_addr;
         blk_din  = sm_din;
      end
   end

   // Channel request, timeout counter, response capture and sticky error
   always_ff @(posedge clk or posedge Rst) begin
      if (Rst) begin
         ch_req    <= '0;
         ch_we     <= 1'b0;
         ch_addr   <= '0;
         ch_wdata  <= '0;
         err       <= 1'b0;
         rdata_q   <= '0;
         cnt_q     <= '0;
         sel_q     <= SelMem;
`ifdef MMIO_ROUTER_STATUS_EN
         tocount_q <= '0;
         last_ch_q <= '0;
         idx_q     <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (access && ch_hit) begin
                  ch_req   <= idx_onehot;
                  ch_we    <= mem_wea;
                  ch_addr  <= mem_addr[7:0];
                  ch_wdata <= mem_din;
                  sel_q    <= SelCh;
`ifdef MMIO_ROUTER_STATUS_EN
                  idx_q    <= idx;
`endif
               end else if (mem_rea && is_mem) begin
                  sel_q <= SelMem;
`ifdef MMIO_ROUTER_STATUS_EN
               end else if (mem_rea && status_hit) begin
                  rdata_q <= status_word;
                  sel_q   <= SelCh;
               end else if (mem_wea && status_hit) begin
                  err       <= 1'b0;
                  tocount_q <= '0;
                  last_ch_q <= '0;
                  sel_q     <= SelZero;
`endif
               end else begin
                  sel_q <= SelZero;
               end
            end
            StWait: begin
               cnt_q <= cnt_q + 1'b1;
               // An ack landing on the expiry cycle still counts as success
               if (ack_hit) begin
                  rdata_q <= rdata_sel;
                  ch_req  <= '0;
               end else if (expire) begin
                  rdata_q <= ERR_DATA;
                  err     <= 1'b1;
                  ch_req  <= '0;
`ifdef MMIO_ROUTER_STATUS_EN
                  tocount_q <= (tocount_q == 16'hFFFF) ? tocount_q : tocount_q + 16'd1;
                  last_ch_q <= idx_q;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule
